// File: rtl/shift_pin_sout_pkg.sv
// Shared constants for the shift_pin_sout transmit shifter: word width,
// counter sizing and reset values.
package shift_pin_sout_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] CNT_FULL = 4'd8;
  localparam logic [CNT_W-1:0] RST_CNT  = '0;
  localparam logic             RST_BIT  = 1'b0;

endpackage

// File: rtl/tx_hold_reg.sv
// One-byte holding register between the producer (load/din) and the
// shifter (xfer strobe); tracks occupancy and a sticky overrun flag.
module tx_hold_reg
  import shift_pin_sout_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [0:WIDTH-1] din,
  input  logic             xfer,
  output logic [0:WIDTH-1] hold_q,
  output logic             hold_full,
  output logic             overrun
);

  // A load that coincides with a transfer refills the register without
  // losing data, so it is never counted as an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= RST_BIT;
      overrun   <= RST_BIT;
    end else if (load) begin
      hold_q    <= din;
      hold_full <= 1'b1;
      if (hold_full && !xfer) overrun <= 1'b1;
    end else if (xfer) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_pin_sout.sv
// Parallel-in serial-out transmit shifter with holding register.
// Optional parity register enabled by defining SHIFT_PIN_SOUT_PARITY_EN.
module shift_pin_sout
  import shift_pin_sout_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select,
  input  logic             le,
  input  logic             load,
  input  logic [0:WIDTH-1] din,
  output logic             dout,
  output logic             parity,
  output logic             hold_full,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] cnt_full = CNT_W'(WIDTH);

  logic [0:WIDTH-1] hold_q;
  logic [0:WIDTH-1] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             xfer;

  // Strobes: select+le transfers hold->shifter, select alone shifts one bit.
  assign xfer = select & le;

  tx_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .xfer      (xfer),
    .hold_q    (hold_q),
    .hold_full (hold_full),
    .overrun   (overrun)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= RST_CNT;
    end else if (xfer) begin
      shift_q <= hold_q;
      cnt_q   <= cnt_full;
    end else if (select) begin
      shift_q <= {shift_q[1:WIDTH-1], 1'b0};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef SHIFT_PIN_SOUT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n) parity_q <= RST_BIT;
    else if (xfer) parity_q <= ^hold_q;
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign dout    = shift_q[0];
  assign bit_cnt = cnt_q;
  assign busy    = (cnt_q != '0);

endmodule

// File: doc/shift_pin_sout.md
# shift_pin_sout

Byte-wide parallel-in, serial-out shift register with a one-byte holding register. It is the transmit half of the CPLD-to-Raspberry-Pi serial link. The TI side (data path) writes a byte into the holding register. The Pi side then, using the same `select` / `le` strobes as the receive shifter, latches that byte into the shifter and clocks it out MSB-first, one bit per strobe. It also reports word parity, occupancy and overrun status.

## Interface
- `WIDTH`, 8: data word width; the counter is sized to hold `WIDTH` (4 bits at default).
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `select`  in  1: shifter enable. While low, shifter, counter and parity register hold.
- `le`  in  1: with `select`, transfers the holding register into the shifter. Without `le`, `select` shifts by one bit.
- `load`  in  1: producer strobe; captures `din` into the holding register. Independent of `select`.
- `din`  in  [0:WIDTH-1]: parallel byte; index 0 is the first bit transmitted.
- `dout`  out  1: serial data, equal to `shift_q[0]` (combinational from the register).
- `parity`  out  1: XOR of the word last transferred into the shifter; constant during its shift-out.
- `hold_full`  out  1: the holding register contains a byte not yet transferred.
- `busy`  out  1: `bit_cnt != 0`.
- `bit_cnt`  out  4: bits remaining in the shifter; range 0..8.
- `overrun`  out  1: sticky flag; a `load` overwrote an untransferred byte.

## Operation
- **Reset** (`rst_n` low at a clock edge): all of the following clear to 0 — `hold_q`, `shift_q`, `bit_cnt`, `parity`, `hold_full`, `overrun`. Therefore `dout`, `busy` and every output read 0. Reset overrides all other inputs, including in the middle of a shift.
- **Load**: `load` high causes `hold_q <= din` and `hold_full <= 1`. If `hold_full` is already 1 and no transfer happens in the same cycle, the new byte overwrites the old one and `overrun <= 1`. `overrun` stays set until reset.
- **Transfer** (`select` and `le`):
  - `shift_q <= hold_q`, `bit_cnt <= WIDTH`, `parity <= ^hold_q`, `hold_full <= 0`.
  - If `hold_full` was 0, the stale `hold_q` is sent again. This is not flagged.
  - A transfer in the middle of a word aborts the remaining bits.
- **Shift** (`select` and not `le`):
  - `shift_q <= {shift_q[1:WIDTH-1], 1'b0}`.
  - `bit_cnt` decrements and saturates at 0.
  - Extra shifts after the word is complete produce 0 on `dout`.
- **Load and transfer in the same cycle**: the shifter receives the old `hold_q` and the holding register receives `din`. `hold_full` ends at 1 and `overrun` is not set.
- **Idle**: `select` low holds every shifter-side register. Loads are still accepted.

## Timing
- A transfer presents bit 0 on `dout` one cycle later; no shift is needed for the first bit.
- Bit k (k ≥ 1) appears on `dout` the cycle after the k-th shift edge following the transfer.
- `busy` rises one cycle after the transfer and falls one cycle after the 8th shift.
- `hold_full` rises one cycle after `load` and falls one cycle after the transfer.
- `overrun` rises one cycle after the offending `load`.
- No combinational path runs from inputs to outputs.

## Configuration
- Macro: `SHIFT_PIN_SOUT_PARITY_EN`.
- Defined: the parity register exists and `parity` behaves as described above.
- Undefined: the parity register is removed and `parity` is tied to 0. All other behaviour is identical.

## Structure
- Shared package holds:
  - the `WIDTH` default of 8;
  - the counter width, 4;
  - the `bit_cnt` full value, 8;
  - the reset values.
- Natural sub-module: `tx_hold_reg`. It contains the holding register, `hold_full` and `overrun` logic. Its inputs are `load`, `din` and a transfer strobe; its outputs are `hold_q`, `hold_full` and `overrun`.
- Top level contains the shifter, counter and parity register.

## Test plan
- **Reset**: hold `rst_n` low 2 cycles with `load`, `select` and `le` all high → every output 0, including `bit_cnt = 0`.
- **Basic word**: `load` with `din = 8'b1010_0101`, then `select`+`le`, then 8 `select` shifts.
  - `dout` sequence: 1,0,1,0,0,1,0,1, then 0.
  - `bit_cnt` counts 8 down to 0; `busy` falls after the 8th shift.
  - `parity = 0`; `hold_full` goes 1 then 0.
- **Odd parity**: `din = 8'b1000_0000` → `parity = 1` (0 when the macro is undefined). A 9th shift keeps `dout = 0` and `bit_cnt = 0`.
- **Overrun**:
  - `load 8'h11`, then `load 8'h22` with no transfer → `overrun = 1`.
  - Transfer and shift → `dout` carries 8'h22 bits.
  - `overrun` stays 1 until reset.
- **Simultaneous load and transfer**:
  - Holding 8'h3C, then `load 8'hC3` together with `select`+`le` → shifter sends 8'h3C, `hold_full = 1`, `overrun = 0`.
  - Next transfer sends 8'hC3.
- **Freeze and reset mid-shift**:
  - `select` low for 5 cycles after the 3rd shift → `dout` and `bit_cnt = 5` are frozen.
  - `rst_n` low mid-word → all outputs 0 the next cycle.
